// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. On an accepted start the operands are
// captured and subtracted one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flop. After WIDTH RUN cycles the result is
// loaded into diff/bout and done pulses for one cycle. diff/bout then hold
// until the next completed operation.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..16)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  capture a/b and begin (accepted in IDLE or DONE, ignored in RUN)
//   a      minuend, sampled on the accepting edge
//   b      subtrahend, sampled on the accepting edge
//   busy   high while an operation is in progress (RUN)
//   done   one-cycle pulse, diff/bout valid
//   diff   a - b modulo 2^WIDTH
//   bout   borrow out, 1 when unsigned a < b
//   ovf    (only with SERIAL_SUB_OVF_EN defined) signed two's-complement
//          overflow of a - b, loaded together with diff
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and its flop.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;     // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] b_sh;     // subtrahend, shifted right each RUN cycle
  logic [WIDTH-1:0] res_sh;   // result bits enter at the MSB end
  logic [CW-1:0]    cnt;
  logic             br;
  logic             armed;    // low only on the first edge after reset release

  logic             a_i;
  logic             b_i;
  logic             d;
  logic             br_next;
  logic             last;
  logic             accept;

  // Full-subtractor cell on the current LSBs.
  assign a_i     = a_sh[0];
  assign b_i     = b_sh[0];
  assign d       = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last    = (cnt == LAST);
  assign accept  = start && armed && (state != RUN);

  // State register.
  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment ahead of the case keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: Moore outputs straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Start is ignored on the first edge after reset release; this flop gates
  // acceptance until that edge has passed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Datapath. Every register, including the operand and result shifters, is
  // cleared by reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {d, res_sh[WIDTH-1:1]};
      br     <= br_next;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= {d, res_sh[WIDTH-1:1]};
        bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // On the last bit a_i/b_i are the operand MSBs and d is the diff MSB.
        ovf  <= (a_i != b_i) && (d != a_i);
`endif
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port start  input  1  request: capture a and b, begin subtraction.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled only on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled only on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse: diff and bout valid.
REQ-009 SHALL have port diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  borrow out; 1 when unsigned a < b.

Function
REQ-011 SHALL implement three states: IDLE, RUN, DONE.
REQ-012 SHALL accept start in IDLE or DONE: capture a, b; clear the borrow flop and the bit counter; enter RUN.
REQ-013 SHALL ignore start while in RUN; captured operands and the in-flight operation stay unchanged.
REQ-014 SHALL, per RUN clock edge, process one bit LSB-first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 SHALL shift each result bit into an internal shift register; diff and bout are not updated until completion.
REQ-016 SHALL take exactly WIDTH RUN edges, then enter DONE, loading diff from the shift register and bout from the final borrow on that same edge.
REQ-017 SHALL assert done only in DONE, for exactly one cycle; done rises WIDTH edges after the accepting edge.
REQ-018 SHALL return from DONE to IDLE when start is low, or re-enter RUN when start is high (back-to-back, no idle cycle).
REQ-019 SHALL hold busy high in RUN only; busy and done are never high together.
REQ-020 SHALL hold diff and bout stable from DONE until the next DONE; they are not cleared by a new start.
REQ-021 SHALL produce a bit counter sized clog2(WIDTH+1) with no wrap or overrun for any legal WIDTH.

Reset
REQ-022 SHALL, while rst_n is low, force state to IDLE and force busy=0, done=0, diff=0, bout=0, borrow flop, counter and shift register to 0, independent of clk.
REQ-023 SHALL abort any operation in progress when reset asserts; no done pulse follows the release.
REQ-024 SHALL ignore start on the first rising edge at which rst_n is already high only if rst_n deasserted within that cycle; start is accepted from the following edge onward.

Configuration
REQ-025 SHALL, when SERIAL_SUB_OVF_EN is defined, add port ovf  output  1: signed two's-complement overflow, (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), loaded with diff, reset to 0, held like diff.
REQ-026 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit port ovf and all of its logic; all other behaviour is identical.

Verification (WIDTH=3)
REQ-027 SHALL cover a=5, b=3, start pulse -> busy for 3 cycles, then done pulse with diff=2, bout=0.
REQ-028 SHALL cover a=3, b=5 -> diff=6 (110), bout=1; a=7, b=7 -> diff=0, bout=0; a=0, b=1 -> diff=7, bout=1.
REQ-029 SHALL cover start held high with a=5, b=3, and the operands changed to a=1, b=2 during RUN -> first result diff=2, bout=0; the next operation, started from DONE, gives diff=7, bout=1.
REQ-030 SHALL cover rst_n pulsed low at RUN bit 1 -> busy=0, diff=0, bout=0 immediately; no done pulse follows; the next start gives a correct result.
REQ-031 SHALL cover, with SERIAL_SUB_OVF_EN defined, a=4 (-4), b=1 -> diff=3, ovf=1; a=2, b=1 -> diff=1, ovf=0.
